// File: rtl/codificador_7_segmentos.sv
// codificador_7_segmentos: observes a multiplexed 4-digit 7-segment display and
//   recovers the shown digit codes, publishing a frame once it has been stable.
// Latency: 1 input register cycle + SETTLE_CYC settle per digit; a stable frame
//   appears on valor the cycle after it completes.
// Backpressure: valor/erro frozen while valido=1 and pronto=0; a newer stable frame
//   waits in a single pending slot (newest wins) and loads at the transfer edge.
// Ports: clk, rst_n (async assert, sync release), segmentos[0:6] (a..g, 1 = lit),
//   digito[3:0] (one-hot strobe), valor[15:0] (nibble n = digit n), erro[3:0],
//   valido, pronto.
// Optional build macro HEX_DECODE_EN: also decodes the A,b,C,d,E,F glyphs.
module codificador_7_segmentos #(
  parameter int SETTLE_CYC    = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:6]  segmentos,
  input  logic [3:0]  digito,
  output logic [15:0] valor,
  output logic [3:0]  erro,
  output logic        valido,
  input  logic        pronto
);

  typedef enum logic [1:0] {ESPERA, ASSENTA, CAPTURADO} estado_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] STABLE_N    = 4'(STABLE_FRAMES);

  // Returns {erro, code}; unknown glyphs give code F with the error bit set.
  function automatic logic [4:0] decode(input logic [0:6] p);
    logic [4:0] r;
    r = 5'h1F;
    case (p)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
`ifdef HEX_DECODE_EN
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
`endif
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Registered input copies; every decision below uses these.
  logic [0:6] seg_q;
  logic [3:0] dig_q;
  logic       dig_onehot;
  assign dig_onehot = (dig_q != 4'd0) && ((dig_q & (dig_q - 4'd1)) == 4'd0);

  // Strobe FSM state
  estado_t    estado_q, estado_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] stb_q, stb_d;
  logic       cap;

  // Slots, history and output state
  logic [15:0] codes_q, codes_d;
  logic [3:0]  errs_q, errs_d, flags_q, flags_d;
  logic [19:0] hist_q, hist_d, pend_q, pend_d, cur;
  logic        hist_vld_q, hist_vld_d, pend_vld_q, pend_vld_d;
  logic [3:0]  stab_q, stab_d;
  logic [15:0] valor_q, valor_d;
  logic [3:0]  erro_q, erro_d;
  logic        valido_q, valido_d, pub_any_q, pub_any_d;
  logic        frame_done, pub_req, xfer;
  logic [4:0]  dec;

  assign dec        = decode(seg_q);
  assign frame_done = &flags_q;
  assign cur        = {errs_q, codes_q};
  assign xfer       = valido_q & pronto;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    stb_d    = stb_q;
    cap      = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (dig_onehot) begin
          estado_d = ASSENTA;
          cnt_d    = 8'd0;
          stb_d    = dig_q;
        end
      end
      ASSENTA, CAPTURADO: begin
        if (dig_q != stb_q) begin
          // A new one-hot strobe restarts settling; blanking waits.
          estado_d = dig_onehot ? ASSENTA : ESPERA;
          cnt_d    = 8'd0;
          stb_d    = dig_q;
        end else if (estado_q == ASSENTA) begin
          if (cnt_q == SETTLE_LAST) begin
            cap      = 1'b1;
            estado_d = CAPTURADO;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_comb begin
    codes_d = codes_q;
    errs_d  = errs_q;
    for (int n = 0; n < 4; n++) begin
      if (cap && stb_q[n]) begin
        codes_d[4*n +: 4] = dec[3:0];
        errs_d[n]         = dec[4];
      end
    end
    flags_d = (frame_done ? 4'd0 : flags_q) | (cap ? stb_q : 4'd0);

    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    stab_d     = stab_q;
    if (frame_done) begin
      if (hist_vld_q && (cur == hist_q))
        stab_d = (stab_q >= STABLE_N) ? STABLE_N : stab_q + 4'd1;
      else
        stab_d = 4'd1;
      hist_d     = cur;
      hist_vld_d = 1'b1;
    end
    pub_req = frame_done && (stab_d == STABLE_N) &&
              (!pub_any_q || (cur != {erro_q, valor_q}));
  end

  always_comb begin
    valor_d    = valor_q;
    erro_d     = erro_q;
    valido_d   = valido_q;
    pub_any_d  = pub_any_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (pub_req) begin
      if (!valido_q || xfer) begin
        {erro_d, valor_d} = cur;
        valido_d   = 1'b1;
        pub_any_d  = 1'b1;
        pend_vld_d = 1'b0;
      end else begin
        pend_d     = cur;
        pend_vld_d = 1'b1;
      end
    end else if (xfer) begin
      if (pend_vld_q) begin
        {erro_d, valor_d} = pend_q;
        pend_vld_d = 1'b0;
      end else begin
        valido_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      seg_q      <= '0;
      dig_q      <= '0;
      estado_q   <= ESPERA;
      cnt_q      <= '0;
      stb_q      <= '0;
      codes_q    <= '0;
      errs_q     <= '0;
      flags_q    <= '0;
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      stab_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      valor_q    <= '0;
      erro_q     <= '0;
      valido_q   <= 1'b0;
      pub_any_q  <= 1'b0;
    end else begin
      seg_q      <= segmentos;
      dig_q      <= digito;
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      stb_q      <= stb_d;
      codes_q    <= codes_d;
      errs_q     <= errs_d;
      flags_q    <= flags_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      stab_q     <= stab_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      valor_q    <= valor_d;
      erro_q     <= erro_d;
      valido_q   <= valido_d;
      pub_any_q  <= pub_any_d;
    end
  end

  assign valor  = valor_q;
  assign erro   = erro_q;
  assign valido = valido_q;

endmodule

// File: tb/tb_codificador_7_segmentos.sv
// tb_codificador_7_segmentos: directed bench for the 7-segment frame decoder.
// Drives scanned digit strobes on the falling edge and checks published frames,
// handshake behaviour, invalid glyphs and mid-frame reset.
module tb_codificador_7_segmentos;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pronto = 1'b0;
  logic [0:6]  segmentos = '0;
  logic [3:0]  digito = '0;
  logic [15:0] valor;
  logic [3:0]  erro;
  logic        valido;

  int checks = 0;
  int failures = 0;
  int vld_total = 0;
  int base = 0;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PBAD = 7'b0000001;
  localparam logic [6:0] PA = 7'b1110111;

  codificador_7_segmentos #(.SETTLE_CYC(4), .STABLE_FRAMES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .segmentos (segmentos),
    .digito    (digito),
    .valor     (valor),
    .erro      (erro),
    .valido    (valido),
    .pronto    (pronto)
  );

  always #5 clk = ~clk;

  // Count cycles with valido high, sampled mid-cycle.
  always @(negedge clk) if (valido) vld_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic show(input int n, input logic [6:0] p, input int cyc);
    @(negedge clk);
    digito    = 4'b0001 << n;
    segmentos = p;
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                      input logic [6:0] p0, input int cyc, input int frames);
    for (int f = 0; f < frames; f++) begin
      show(3, p3, cyc);
      show(2, p2, cyc);
      show(1, p1, cyc);
      show(0, p0, cyc);
    end
    @(negedge clk);
    digito    = 4'd0;
    segmentos = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pronto = 1'b0; digito = 4'd0; segmentos = '0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic snap();
    @(posedge clk);
    base = vld_total;
  endtask

  task automatic pulses(input string tag, input int exp);
    @(posedge clk);
    check(tag, vld_total - base, exp);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_valor", valor, 16'h0000);
    check("rst_erro", erro, 4'h0);
    check("rst_valido", valido, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // "2024", 8-cycle strobes, 3 frames, consumer always ready
    pronto = 1'b1;
    snap();
    scan(P2, P0, P2, P4, 8, 3);
    idle(10);
    check("t1_valor", valor, 16'h2024);
    check("t1_erro", erro, 4'h0);
    check("t1_valido_low", valido, 1'b0);
    pulses("t1_pulses", 1);

    // Strobes too short to settle
    do_reset();
    pronto = 1'b1;
    snap();
    scan(P2, P0, P2, P4, 2, 4);
    idle(10);
    check("t2_valido", valido, 1'b0);
    check("t2_valor", valor, 16'h0000);
    pulses("t2_pulses", 0);

    // Invalid glyph on digit 1, then the same frame repeated
    do_reset();
    pronto = 1'b1;
    snap();
    scan(P1, P2, PBAD, P3, 8, 3);
    idle(10);
    check("t3_valor", valor, 16'h12F3);
    check("t3_erro", erro, 4'b0010);
    pulses("t3_pulses", 1);
    snap();
    scan(P1, P2, PBAD, P3, 8, 3);
    idle(10);
    pulses("t3_repeat_pulses", 0);
    check("t3_repeat_valor", valor, 16'h12F3);

    // Backpressure: 1234 held, 5678 pending until the transfer
    do_reset();
    pronto = 1'b0;
    scan(P1, P2, P3, P4, 8, 3);
    idle(5);
    check("t4_valido_1234", valido, 1'b1);
    check("t4_valor_1234", valor, 16'h1234);
    scan(P5, P6, P7, P8, 8, 3);
    idle(5);
    check("t4_frozen_valor", valor, 16'h1234);
    check("t4_frozen_valido", valido, 1'b1);
    @(negedge clk);
    pronto = 1'b1;
    @(negedge clk);
    check("t4_pending_valor", valor, 16'h5678);
    check("t4_pending_valido", valido, 1'b1);
    pronto = 1'b0;
    idle(3);
    check("t4_hold_valor", valor, 16'h5678);
    pronto = 1'b1;
    @(negedge clk);
    pronto = 1'b0;
    idle(2);
    check("t4_drained_valido", valido, 1'b0);

    // Hex glyph "A" on every digit
    do_reset();
    pronto = 1'b1;
    scan(PA, PA, PA, PA, 8, 3);
    idle(10);
`ifdef HEX_DECODE_EN
    check("t5_valor", valor, 16'hAAAA);
    check("t5_erro", erro, 4'h0);
`else
    check("t5_valor", valor, 16'hFFFF);
    check("t5_erro", erro, 4'hF);
`endif

    // Reset after 2 of 3 stable frames
    do_reset();
    pronto = 1'b1;
    scan(P2, P0, P2, P4, 8, 3);
    idle(10);
    check("t6_pre_valor", valor, 16'h2024);
    scan(P9, P8, P7, P6, 8, 2);
    show(3, P9, 8);
    @(negedge clk);
    rst_n  = 1'b0;
    digito = 4'd0;
    #1;
    check("t6_rst_valor", valor, 16'h0000);
    check("t6_rst_erro", erro, 4'h0);
    check("t6_rst_valido", valido, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    snap();
    scan(P9, P8, P7, P6, 8, 2);
    idle(10);
    pulses("t6_two_frames_pulses", 0);
    check("t6_two_frames_valor", valor, 16'h0000);
    snap();
    scan(P9, P8, P7, P6, 8, 1);
    idle(10);
    pulses("t6_third_frame_pulses", 1);
    check("t6_third_frame_valor", valor, 16'h9876);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
